// File: rtl/uart_tx_stream_control_if.sv
`default_nettype none
// ============================================================================
// uart_tx_stream_control_if
//   Control, memory-read and uart_tx handshake bundle for uart_tx_stream_control.
//   Revision: 1.0
// ============================================================================
interface uart_tx_stream_control_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   byte_count;
    logic                  continuous;
    logic                  abort;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic [ADDR_WIDTH-1:0] mem_read_addr;
    logic                  mem_read_enable;
    logic [DATA_WIDTH-1:0] uart_tx_data;
    logic                  uart_tx_start;
    logic                  uart_tx_done;
    logic                  busy;
    logic                  transmission_done;
    logic                  aborted;
    logic [ADDR_WIDTH:0]   bytes_sent;

    modport master (
        input  start, base_addr, byte_count, continuous, abort,
        input  mem_read_data, uart_tx_done,
        output mem_read_addr, mem_read_enable, uart_tx_data, uart_tx_start,
        output busy, transmission_done, aborted, bytes_sent
    );

    modport slave (
        output start, base_addr, byte_count, continuous, abort,
        output mem_read_data, uart_tx_done,
        input  mem_read_addr, mem_read_enable, uart_tx_data, uart_tx_start,
        input  busy, transmission_done, aborted, bytes_sent
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_stream_control.sv
`default_nettype none
// ============================================================================
// uart_tx_stream_control
//   Streams a window of memory bytes into uart_tx, one start/done handshake each.
//   Revision: 1.0
// ============================================================================
module uart_tx_stream_control #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int MEM_LATENCY = 1,
    parameter int GAP_CYCLES  = 0
) (
    input  wire logic                clk,
    input  wire logic                rstn,
    uart_tx_stream_control_if.master bus
);
    localparam int c_MAX_WAIT = (MEM_LATENCY > GAP_CYCLES) ? MEM_LATENCY : GAP_CYCLES;
    localparam int c_CNT_W    = (c_MAX_WAIT > 1) ? $clog2(c_MAX_WAIT) : 1;
    localparam logic [c_CNT_W-1:0]    c_DELAY_LAST = c_CNT_W'(MEM_LATENCY - 1);
    localparam logic [c_CNT_W-1:0]    c_GAP_LAST   = c_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE    = 1;
    localparam logic [ADDR_WIDTH:0]   c_SENT_ONE   = 1;
    localparam bit                    c_HAS_GAP    = (GAP_CYCLES > 0);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_DELAY    = 3'd2,
        S_TRANSMIT = 3'd3,
        S_WAIT     = 3'd4,
        S_GAP      = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   r_bytes_sent;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_abort_hit;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_en;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_start;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_aborted;

    logic [ADDR_WIDTH:0]   w_check_sent;
    logic                  w_pass_end;

    // The pass-end decision happens either straight out of WAIT (no gap) or at
    // the last GAP cycle; in WAIT the byte just finished is not yet counted.
    always_comb begin
        w_check_sent = (r_state == S_WAIT) ? (r_bytes_sent + c_SENT_ONE) : r_bytes_sent;
        w_pass_end   = 1'b0;
        if (r_state == S_WAIT) begin
            w_pass_end = bus.uart_tx_done && !c_HAS_GAP;
        end else if (r_state == S_GAP) begin
            w_pass_end = (r_cnt == c_GAP_LAST);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_count      <= '0;
            r_bytes_sent <= '0;
            r_cnt        <= '0;
            r_abort_hit  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_en     <= 1'b0;
            r_tx_data    <= '0;
            r_tx_start   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_mem_en   <= 1'b0;
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_base       <= bus.base_addr;
                        r_count      <= bus.byte_count;
                        r_bytes_sent <= '0;
                        r_abort_hit  <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= (bus.byte_count == '0) ? S_DONE : S_READ;
                    end
                end
                S_READ: begin
                    if (bus.abort) begin
                        r_abort_hit <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_mem_addr <= r_base + r_bytes_sent[ADDR_WIDTH-1:0];
                        r_mem_en   <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (r_cnt == c_DELAY_LAST) begin
                        r_state <= S_TRANSMIT;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_TRANSMIT: begin
                    r_tx_data  <= bus.mem_read_data;
                    r_tx_start <= 1'b1;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.uart_tx_done) begin
                        r_bytes_sent <= r_bytes_sent + c_SENT_ONE;
                        if (c_HAS_GAP) begin
                            r_cnt   <= '0;
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (r_cnt != c_GAP_LAST) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_DONE: begin
                    r_done      <= 1'b1;
                    r_aborted   <= r_abort_hit;
                    r_abort_hit <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase

            // Overrides the WAIT/GAP bookkeeping above, including the clear on repeat.
            if (w_pass_end) begin
                if (bus.abort) begin
                    r_abort_hit <= 1'b1;
                    r_state     <= S_DONE;
                end else if (w_check_sent < r_count) begin
                    r_state <= S_READ;
                end else if (bus.continuous) begin
                    r_done       <= 1'b1;
                    r_bytes_sent <= '0;
                    r_state      <= S_READ;
                end else begin
                    r_state <= S_DONE;
                end
            end
        end
    end

    assign bus.mem_read_addr     = r_mem_addr;
    assign bus.mem_read_enable   = r_mem_en;
    assign bus.uart_tx_data      = r_tx_data;
    assign bus.uart_tx_start     = r_tx_start;
    assign bus.busy              = r_busy;
    assign bus.transmission_done = r_done;
    assign bus.aborted           = r_aborted;
    assign bus.bytes_sent        = r_bytes_sent;
endmodule
`default_nettype wire

// File: doc/uart_tx_stream_control.md
Name: uart_tx_stream_control

Overview:
Parametrised successor to the fixed-length UART TX control FSM. It streams a run-time-selected window of bytes from a synchronous read memory into the uart_tx serialiser, one byte per uart_tx_start/uart_tx_done handshake. It adds a start trigger, programmable base address and length, configurable memory latency, an inter-byte gap, continuous (repeat) mode and a graceful abort. It sits between the message ROM/RAM and uart_tx in the UART control system.

Parameters:
DATA_WIDTH, 8, width of memory words and UART payload
ADDR_WIDTH, 4, memory address width; addresses wrap modulo 2**ADDR_WIDTH
MEM_LATENCY, 1, cycles from mem_read_enable high to valid mem_read_data (>=1)
GAP_CYCLES, 0, idle cycles inserted after each uart_tx_done before the next read (0 = none)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  begin a transfer; sampled only in IDLE
base_addr  in  ADDR_WIDTH  first address; captured on accepted start
byte_count  in  ADDR_WIDTH+1  bytes per pass (0..2**ADDR_WIDTH); captured on accepted start
continuous  in  1  1 = restart at base_addr after each pass; sampled at each pass end
abort  in  1  level; request stop at the next byte boundary
mem_read_data  in  DATA_WIDTH  memory read data
mem_read_addr  out  ADDR_WIDTH  memory read address
mem_read_enable  out  1  one-cycle read strobe per byte
uart_tx_data  out  DATA_WIDTH  byte to uart_tx; held stable until the next TRANSMIT
uart_tx_start  out  1  one-cycle pulse to uart_tx
uart_tx_done  in  1  uart_tx finished the current byte
busy  out  1  high in every state except IDLE
transmission_done  out  1  one-cycle pulse at the end of each pass or abort
aborted  out  1  one-cycle pulse, coincident with transmission_done when the stop was due to abort
bytes_sent  out  ADDR_WIDTH+1  bytes completed in the current pass; held after done until the next accepted start

Behaviour:
- Reset (asynchronous assert, synchronous release): every output is 0; state is IDLE; internal counters are 0.
- All outputs are registered.
- IDLE:
  - start=1 -> latch base_addr and byte_count, clear bytes_sent, go to READ.
  - start=1 with byte_count=0 -> go to DONE instead; no memory or UART activity.
- READ:
  - If abort=1 -> DONE with aborted.
  - Otherwise drive mem_read_addr = base + bytes_sent (wrapped) and pulse mem_read_enable for 1 cycle, then go to DELAY.
- DELAY: hold for MEM_LATENCY cycles, then go to TRANSMIT.
- TRANSMIT:
  - Register mem_read_data into uart_tx_data and pulse uart_tx_start for 1 cycle, then go to WAIT.
  - uart_tx_data changes only in this state.
- WAIT:
  - Remain until uart_tx_done=1, then increment bytes_sent.
  - Next state: GAP if GAP_CYCLES>0, else the pass-end check.
  - abort never truncates a byte in flight; it is honoured only after uart_tx_done.
- GAP: count GAP_CYCLES cycles, then run the pass-end check.
- Pass-end check:
  - bytes_sent < count and abort=0 -> READ.
  - abort=1 -> DONE with aborted.
  - bytes_sent == count and continuous=0 -> DONE.
  - bytes_sent == count and continuous=1 -> pulse transmission_done, clear bytes_sent, go to READ at base_addr. Latched count/base are reused; busy stays high.
- DONE: pulse transmission_done (and aborted if applicable) for 1 cycle, then go to IDLE.
- start while busy is ignored; start is not queued.
- Timing with MEM_LATENCY=1, start high at edge E0:
  - mem_read_enable high in the cycle after E1.
  - uart_tx_start high in the cycle after E3.
  - Per-byte period = 3 + MEM_LATENCY + GAP_CYCLES + cycles waiting in WAIT.
- uart_tx_done outside WAIT is ignored.
- Address wrap: base=14, count=4 -> addresses 14, 15, 0, 1.
- Reset asserted mid-transfer: outputs clear immediately; no done pulse is produced.
- Unreachable state encodings -> IDLE.

Test Plan:
- Defaults; ROM[0..3]=A1,B2,C3,D4; base=0, count=4; uart_tx_done 10 cycles after each start -> uart_tx_data sequence A1,B2,C3,D4; exactly 4 uart_tx_start pulses; one transmission_done; bytes_sent=4; aborted=0.
- base=14, count=4 -> mem_read_addr sequence 14,15,0,1; 4 bytes sent.
- count=0 with start -> transmission_done pulses 2 cycles after start; mem_read_enable and uart_tx_start never assert.
- MEM_LATENCY=3, GAP_CYCLES=5 -> uart_tx_data equals the addressed ROM word; exactly 5 cycles between uart_tx_done and the next mem_read_enable.
- continuous=1, count=2 -> addresses 0,1,0,1,...; transmission_done after every 2nd byte; busy never drops. Then drop continuous -> stops after the current pass.
- abort raised during byte 2 of 4 -> byte 2 completes (uart_tx_done honoured); no byte-3 read; transmission_done and aborted pulse together; bytes_sent=2. Then rstn pulled low mid-byte -> all outputs 0 asynchronously.
